disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit stays lit (legal 2..2^20).
REQ-002 The block SHALL have parameter LZ_BLANK, default 1, meaning leading-zero blanking is enabled when 1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 bin_in  input  14  unsigned binary value to show (litres/price count).
REQ-006 load  input  1  request to convert and show bin_in; sampled every clock.
REQ-007 busy  output  1  conversion in progress; load is ignored while high.
REQ-008 digit_cnt  output  4  BCD digit of the currently scanned position, drives the 7-segment decoder cnt input.
REQ-009 an  output  4  active-low digit enables; bit i lights digit i (0 = least significant).

Function
REQ-010 All outputs SHALL be registered.
REQ-011 Conversion FSM SHALL have states IDLE, CONV, COMMIT.
REQ-012 IDLE -> CONV when load=1 and busy=0; bin_in is captured that cycle and saturated to 9999 if greater.
REQ-013 CONV SHALL run exactly 14 shift-add-3 iterations (one per cycle) on a 16-bit BCD accumulator, then go to COMMIT.
REQ-014 COMMIT SHALL copy the 4 BCD digits atomically into the display buffer in one cycle, then return to IDLE.
REQ-015 busy SHALL be 1 in the cycle after load acceptance through the COMMIT cycle inclusive: 15 cycles total; digit_cnt reflects the new value from the cycle after COMMIT.
REQ-016 load asserted while busy=1 SHALL be dropped, not queued; load held high SHALL retrigger on the first cycle busy is 0.
REQ-017 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-018 an SHALL be all-ones except bit [index] low; digit_cnt SHALL be buffer[index].
REQ-019 With LZ_BLANK=1, a digit at index>0 SHALL be blanked (an=4'b1111) when it and all more-significant digits are zero; digit 0 is never blanked.
REQ-020 Scanning SHALL continue unaffected during conversion; a buffer update in COMMIT SHALL NOT reset the prescaler or index.
REQ-021 digit_cnt SHALL only ever carry values 0..9.

Reset
REQ-022 On rst_n=0 at a clock edge: state IDLE, busy 0, buffer all zero, index 0, prescaler 0, digit_cnt 0, an 4'b1110.
REQ-023 Reset during CONV or COMMIT SHALL abort the conversion with no partial buffer update.
REQ-024 The first load after reset release SHALL be accepted in the same cycle it is sampled.

Structure
REQ-025 Shared package disp_pkg SHALL hold the FSM state enum, NDIG=4, MAX_VAL=9999 and the BCD digit typedef (4 bits).
REQ-026 The iterative converter SHALL be a sub-module bin2bcd_seq (start, bin, busy, done, bcd[15:0]); prescaler, scan and blanking stay in disp_scan_ctrl.
REQ-027 The 7-segment decoder SHALL NOT be instantiated inside this block; the top level connects digit_cnt to it.

Verification (bench SCAN_DIV=4)
REQ-028 Reset then no load -> an cycles 1110 only (LZ_BLANK=1), digit_cnt 0 throughout.
REQ-029 load with bin_in=1234 -> busy high exactly 15 cycles; then over 16 cycles an sequence 1110,1101,1011,0111 with digit_cnt 4,3,2,1.
REQ-030 bin_in=12000 -> displayed digits 9,9,9,9 (saturation).
REQ-031 bin_in=7 with LZ_BLANK=1 -> digit 0 shows 7, indices 1..3 an=1111; with LZ_BLANK=0 -> digits 7,0,0,0 all lit.
REQ-032 load 0042 accepted, second load 9999 pulsed 5 cycles later -> second ignored, display shows 42; held-high load after busy drop -> 9999 accepted.
REQ-033 rst_n low at CONV iteration 8 of value 5678 -> buffer remains zero, busy 0, an=1110 next cycle.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller and its BCD converter.
package disp_pkg;

    localparam int unsigned NDIG    = 4;
    localparam int unsigned MAX_VAL = 9999;
    localparam int unsigned BIN_W   = 14;
    localparam int unsigned BCD_W   = 16;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StCommit
    } conv_state_e;

    function automatic logic [BIN_W-1:0] sat_bin(input logic [BIN_W-1:0] v);
        return (v > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : v;
    endfunction

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int i = 0; i < NDIG; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one bit per clock.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [BCD_W-1:0] acc_adj;

    always_comb begin
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        acc_adj = add3_digits(acc_q);
        if (start && !busy_q) begin
            sr_d   = bin;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = {acc_adj[BCD_W-2:0], sr_q[BIN_W-1]};
            sr_d  = {sr_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(BIN_W - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done flags the cycle performing the final iteration; bcd is complete after it.
    assign done = busy_q && (cnt_q == 4'(BIN_W - 1));
    assign busy = busy_q;
    assign bcd  = acc_q;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Converts a binary count to BCD and multiplexes it onto a 4-digit 7-segment display.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    output logic [3:0]       digit_cnt,
    output logic [NDIG-1:0]  an
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    conv_state_e                 state_q, state_d;
    logic                        busy_q, busy_d;
    bcd_digit_t [NDIG-1:0]       buf_q, buf_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [1:0]                  idx_q, idx_d;
    logic [3:0]                  digit_cnt_q, digit_cnt_d;
    logic [NDIG-1:0]             an_q, an_d;

    logic                        conv_start;
    logic                        conv_busy;
    logic                        conv_done;
    logic [BCD_W-1:0]            conv_bcd;
    logic                        blank;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (sat_bin(bin_in)),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        buf_d      = buf_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    conv_start = 1'b1;
                    state_d    = StConv;
                end
            end
            StConv: begin
                if (conv_done) begin
                    state_d = StCommit;
                end else if (!conv_busy) begin
                    state_d = StIdle;
                end
            end
            StCommit: begin
                buf_d   = conv_bcd;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // Outputs are built from next-state buffer/index so a commit shows up one cycle later.
    always_comb begin
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end
        digit_cnt_d = buf_d[idx_d];
        blank       = 1'b0;
        if ((LZ_BLANK != 0) && (idx_d != 2'd0)) begin
            blank = 1'b1;
            for (int j = 0; j < NDIG; j++) begin
                if ((j >= int'(idx_d)) && (buf_d[j] != 4'd0)) begin
                    blank = 1'b0;
                end
            end
        end
        an_d = blank ? {NDIG{1'b1}} : ~(NDIG'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            buf_q       <= '0;
            presc_q     <= '0;
            idx_q       <= '0;
            digit_cnt_q <= '0;
            an_q        <= 4'b1110;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            buf_q       <= buf_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            digit_cnt_q <= digit_cnt_d;
            an_q        <= an_d;
        end
    end

    assign busy      = busy_q;
    assign digit_cnt = digit_cnt_q;
    assign an        = an_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench: driver queues expected displays, monitor checks on busy-fall/reset events.
module tb_disp_scan_ctrl;

    localparam int unsigned SD = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy_a, busy_b;
    logic [3:0]  dc_a, dc_b, an_a, an_b;

    disp_scan_ctrl #(.SCAN_DIV(SD), .LZ_BLANK(1)) u_dut_lz (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_in    (bin_in),
        .load      (load),
        .busy      (busy_a),
        .digit_cnt (dc_a),
        .an        (an_a)
    );

    disp_scan_ctrl #(.SCAN_DIV(SD), .LZ_BLANK(0)) u_dut_nolz (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_in    (bin_in),
        .load      (load),
        .busy      (busy_b),
        .digit_cnt (dc_b),
        .an        (an_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        bit          is_reset;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          win_left = 0;
    int unsigned scan_n   = 0;
    bit          rst_at_edge = 1'b0;

    // Independent scan model: edges since the last reset edge.
    always @(posedge clk) begin
        rst_at_edge <= !rst_n;
        if (!rst_n) scan_n <= 0;
        else        scan_n <= scan_n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic note_fail(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    task automatic check_pos(input logic [15:0] cur);
        int unsigned idx;
        logic [3:0]  exp_dc;
        logic [3:0]  lit;
        logic [15:0] upper;
        idx    = (scan_n / SD) % 4;
        exp_dc = cur[idx*4 +: 4];
        lit    = 4'b0001 << idx;
        lit    = ~lit;
        upper  = cur >> (idx * 4);
        chk("digit_cnt_lz", 32'(dc_a), 32'(exp_dc));
        chk("an_lz", 32'(an_a), ((idx != 0) && (upper == 16'h0)) ? 32'hF : 32'(lit));
        chk("digit_cnt_nolz", 32'(dc_b), 32'(exp_dc));
        chk("an_nolz", 32'(an_b), 32'(lit));
    endtask

    // Monitor: a reset edge or a busy fall opens a 16-cycle window on the popped entry.
    initial begin
        int          blen;
        logic        prev_busy;
        logic [15:0] cur;
        exp_t        e;
        blen      = 0;
        prev_busy = 1'b0;
        cur       = '0;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                if (exp_q.size() == 0) begin
                    note_fail("scoreboard", "reset event with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_reset) note_fail("event_kind", "reset seen, conversion expected");
                    cur      = e.bcd;
                    win_left = 16;
                    chk("busy_after_reset", 32'(busy_a), 32'd0);
                end
                blen = 0;
            end else if (busy_a === 1'b1) begin
                blen++;
            end else if (prev_busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    note_fail("scoreboard", "busy fall with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_reset) note_fail("event_kind", "conversion seen, reset expected");
                    chk("busy_len", 32'(blen), 32'd15);
                    cur      = e.bcd;
                    win_left = 16;
                end
                blen = 0;
            end
            if (win_left > 0) begin
                check_pos(cur);
                win_left--;
            end
            prev_busy = busy_a;
        end
    end

    task automatic wait_quiet();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && (win_left == 0)) return;
        end
        note_fail("timeout", "scoreboard did not drain");
        exp_q.delete();
    endtask

    task automatic convert(input logic [13:0] v, input logic [15:0] exp_bcd);
        exp_q.push_back('{bcd: exp_bcd, is_reset: 1'b0});
        @(negedge clk);
        bin_in = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    initial begin
        bit seen_drop;
        exp_q.push_back('{bcd: 16'h0000, is_reset: 1'b1});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_quiet();

        convert(14'd1234, 16'h1234);
        wait_quiet();
        convert(14'd12000, 16'h9999);
        wait_quiet();
        convert(14'd7, 16'h0007);
        wait_quiet();

        // Pulse during busy is dropped; a held load retriggers once busy clears.
        exp_q.push_back('{bcd: 16'h0042, is_reset: 1'b0});
        exp_q.push_back('{bcd: 16'h9999, is_reset: 1'b0});
        @(negedge clk);
        bin_in = 14'd42;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        repeat (4) @(negedge clk);
        bin_in = 14'd9999;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        repeat (4) @(negedge clk);
        load      = 1'b1;
        seen_drop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_a === 1'b0) begin
                seen_drop = 1'b1;
                break;
            end
        end
        if (!seen_drop) note_fail("held_load", "busy never dropped");
        @(negedge clk);
        chk("held_retrigger", 32'(busy_a), 32'd1);
        load = 1'b0;
        wait_quiet();

        // Reset at iteration 8 aborts; the load sampled right after release is taken at once.
        exp_q.push_back('{bcd: 16'h0000, is_reset: 1'b1});
        exp_q.push_back('{bcd: 16'h0321, is_reset: 1'b0});
        @(negedge clk);
        bin_in = 14'd5678;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        repeat (7) @(negedge clk);
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        bin_in = 14'd321;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        chk("first_load_accept", 32'(busy_a), 32'd1);
        wait_quiet();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
